// File: rtl/numbers_grid_manager_if.sv
// Bus between the number-grid manager and its frame/pixel source and sprite renderer.
interface numbers_grid_manager_if #(
  parameter int COLS = 6,
  parameter int ROWS = 3
);
  localparam int N     = COLS * ROWS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic                       startOfFrame_i;
  logic [10:0]                pixelX_i;
  logic [10:0]                pixelY_i;
  logic [N-1:0][3:0]          numbersToShow_i;
  logic [COLS-1:0][15:0]      columnSpeeds_i;
  logic [N-1:0]               singleHit_i;

  logic                       numDR_o;
  logic [IDX_W-1:0]           numIndex_o;
  logic [3:0]                 numDigit_o;
  logic [5:0]                 offsetX_o;
  logic [5:0]                 offsetY_o;
  logic [N-1:0]               showNum_o;

  modport master (
    output startOfFrame_i, pixelX_i, pixelY_i, numbersToShow_i, columnSpeeds_i, singleHit_i,
    input  numDR_o, numIndex_o, numDigit_o, offsetX_o, offsetY_o, showNum_o
  );

  modport slave (
    input  startOfFrame_i, pixelX_i, pixelY_i, numbersToShow_i, columnSpeeds_i, singleHit_i,
    output numDR_o, numIndex_o, numDigit_o, offsetX_o, offsetY_o, showNum_o
  );
endinterface

// File: rtl/numbers_grid_manager.sv
// Grid of number sprites: per-column sub-pixel motion with wrap, per-number
// hit/hide/blink lifecycle, and a one-cycle pixel resolver for the digit renderer.
module numbers_grid_manager #(
  parameter int COLS         = 6,
  parameter int ROWS         = 3,
  parameter int NUM_W        = 32,
  parameter int NUM_H        = 32,
  parameter int X_START      = 150,
  parameter int X_STEP       = 50,
  parameter int Y_START      = 80,
  parameter int Y_STEP       = 100,
  parameter int SCREEN_W     = 640,
  parameter int SPEED_FRAC   = 4,
  parameter int HIDE_FRAMES  = 450,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_PERIOD = 8
) (
  input logic                   clk,
  input logic                   rst,
  numbers_grid_manager_if.slave bus
);
  localparam int N         = COLS * ROWS;
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;
  localparam int AW        = 11 + SPEED_FRAC + 1;
  localparam int BW        = $clog2(BLINK_FRAMES + 1);
  localparam int WRAP_SPAN = (SCREEN_W + NUM_W) * (1 << SPEED_FRAC);

  typedef enum logic [1:0] {VISIBLE, HIDDEN, BLINK} num_state_e;

  logic signed [AW-1:0] acc_q [COLS];
  logic signed [AW-1:0] acc_d [COLS];
  logic signed [31:0]   col_x [COLS];

  num_state_e           st_q  [N];
  num_state_e           st_d  [N];
  logic [8:0]           tmr_q [N];
  logic [8:0]           tmr_d [N];
  logic [BW-1:0]        bc_q  [N];
  logic [BW-1:0]        bc_d  [N];
  logic [N-1:0]         show;

  logic signed [31:0]   px, py;
  logic                 hit_any;
  logic [IDX_W-1:0]     win_idx;
  logic [5:0]           win_ox, win_oy;

  logic                 dr_q;
  logic [IDX_W-1:0]     idx_q;
  logic [3:0]           dig_q;
  logic [5:0]           ox_q, oy_q;

  // Column X (pre-update) and next accumulator; wrap subtracts a whole-pixel span so the fraction survives
  always_comb begin
    logic signed [31:0] ext, spd, sum, sx;
    for (int c = 0; c < COLS; c++) begin
      ext      = {{(32-AW){acc_q[c][AW-1]}}, acc_q[c]};
      spd      = {{16{bus.columnSpeeds_i[c][15]}}, bus.columnSpeeds_i[c]};
      col_x[c] = ext >>> SPEED_FRAC;
      sum      = ext + spd;
      sx       = sum >>> SPEED_FRAC;
      if (sx >= SCREEN_W)   sum = sum - WRAP_SPAN;
      else if (sx < -NUM_W) sum = sum + WRAP_SPAN;
      acc_d[c] = bus.startOfFrame_i ? AW'(sum) : acc_q[c];
    end
  end

  // Column accumulators, reset to evenly spaced start positions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++)
        acc_q[c] <= AW'((X_START + c * X_STEP) * (1 << SPEED_FRAC));
    end else begin
      for (int c = 0; c < COLS; c++) acc_q[c] <= acc_d[c];
    end
  end

  // Per-number lifecycle: a hit only lands while visible; timer counts frames down through hide and blink
  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      bc_d[i]  = bc_q[i];
      show[i]  = 1'b1;
      case (st_q[i])
        VISIBLE: begin
          if (bus.singleHit_i[i]) begin
            st_d[i]  = HIDDEN;
            tmr_d[i] = 9'(HIDE_FRAMES);
          end
        end
        HIDDEN: begin
          show[i] = 1'b0;
          if (bus.startOfFrame_i) begin
            tmr_d[i] = tmr_q[i] - 9'd1;
            if (tmr_q[i] - 9'd1 == 9'(BLINK_FRAMES)) begin
              st_d[i] = BLINK;
              bc_d[i] = '0;
            end
          end
        end
        BLINK: begin
          show[i] = ((bc_q[i] / BW'(BLINK_PERIOD)) & BW'(1)) != '0;
          if (bus.startOfFrame_i) begin
            tmr_d[i] = tmr_q[i] - 9'd1;
            bc_d[i]  = bc_q[i] + BW'(1);
            if (tmr_q[i] == 9'd1) st_d[i] = VISIBLE;
          end
        end
        default: st_d[i] = VISIBLE;
      endcase
    end
  end

  // Per-number state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= VISIBLE;
        tmr_q[i] <= '0;
        bc_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
        bc_q[i]  <= bc_d[i];
      end
    end
  end

  // Pixel resolve: signed compare clips sprites hanging off the left edge; lowest shown index wins
  always_comb begin
    px      = {21'd0, bus.pixelX_i};
    py      = {21'd0, bus.pixelY_i};
    hit_any = 1'b0;
    win_idx = '0;
    win_ox  = '0;
    win_oy  = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!hit_any && show[c*ROWS+r] &&
            px >= col_x[c] && px < col_x[c] + NUM_W &&
            py >= Y_START + r * Y_STEP && py < Y_START + r * Y_STEP + NUM_H) begin
          hit_any = 1'b1;
          win_idx = IDX_W'(c * ROWS + r);
          win_ox  = 6'(px - col_x[c]);
          win_oy  = 6'(py - (Y_START + r * Y_STEP));
        end
      end
    end
  end

  // Registered renderer outputs; sprite fields hold when no sprite covers the pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_q  <= 1'b0;
      idx_q <= '0;
      dig_q <= '0;
      ox_q  <= '0;
      oy_q  <= '0;
    end else begin
      dr_q <= hit_any;
      if (hit_any) begin
        idx_q <= win_idx;
        dig_q <= bus.numbersToShow_i[win_idx];
        ox_q  <= win_ox;
        oy_q  <= win_oy;
      end
    end
  end

  assign bus.numDR_o    = dr_q;
  assign bus.numIndex_o = idx_q;
  assign bus.numDigit_o = dig_q;
  assign bus.offsetX_o  = ox_q;
  assign bus.offsetY_o  = oy_q;
  assign bus.showNum_o  = show;
endmodule

// File: tb/tb_numbers_grid_manager.sv
// Bench for numbers_grid_manager: directed scenarios plus random traffic against a frame-age model.
module tb_numbers_grid_manager;
  localparam int COLS = 6, ROWS = 3, N = 18, NUM_W = 32, NUM_H = 32, SCREEN_W = 640;
  localparam int SF = 4, HIDE = 450, BLINKF = 60, BP = 8;
  localparam int X0 = 150, XS = 50, Y0 = 80, YS = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  numbers_grid_manager_if #(.COLS(COLS), .ROWS(ROWS)) bus ();
  numbers_grid_manager #(.COLS(COLS), .ROWS(ROWS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: column position in 1/16 px, and frames elapsed since a number was hit (-1 = visible)
  int acc_m [COLS];
  int age   [N];
  int e_dr, e_idx, e_dig, e_ox, e_oy;

  function automatic int col_pos(int c);
    return acc_m[c] >>> SF;
  endfunction

  function automatic bit shown(int i);
    if (age[i] < 0) return 1'b1;
    if (age[i] <= HIDE - BLINKF) return 1'b0;
    return (((age[i] - (HIDE - BLINKF)) / BP) % 2) == 1;
  endfunction

  function automatic logic [N-1:0] exp_show();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = shown(i);
    return v;
  endfunction

  function automatic logic [21:0] exp_pix();
    return {1'(e_dr), 5'(e_idx), 4'(e_dig), 6'(e_ox), 6'(e_oy)};
  endfunction

  function automatic logic [21:0] dut_pix();
    return {bus.numDR_o, bus.numIndex_o, bus.numDigit_o, bus.offsetX_o, bus.offsetY_o};
  endfunction

  function automatic int lit4(int f);
    case (f)
      1, 200, 390, 397, 406, 422:        return 0;
      398, 405, 414, 449, 450, 451:      return 1;
      default:                           return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) acc_m[c] = (X0 + c * XS) * 16;
    for (int i = 0; i < N; i++) age[i] = -1;
    e_dr = 0; e_idx = 0; e_dig = 0; e_ox = 0; e_oy = 0;
  endtask

  // One clock: model resolves the pixel with pre-edge state, then advances lifecycle and motion
  task automatic step(input bit sof);
    int px, py, x, y;
    bit found;
    bus.startOfFrame_i = sof;
    px = int'(bus.pixelX_i);
    py = int'(bus.pixelY_i);
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      x = col_pos(i / ROWS);
      y = Y0 + (i % ROWS) * YS;
      if (!found && shown(i) && px >= x && px < x + NUM_W && py >= y && py < y + NUM_H) begin
        found = 1'b1;
        e_idx = i;
        e_dig = int'(bus.numbersToShow_i[i]);
        e_ox  = px - x;
        e_oy  = py - y;
      end
    end
    e_dr = found ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      if (age[i] < 0) begin
        if (bus.singleHit_i[i]) age[i] = 0;
      end else if (sof) begin
        age[i]++;
        if (age[i] >= HIDE) age[i] = -1;
      end
    end
    if (sof) begin
      for (int c = 0; c < COLS; c++) begin
        acc_m[c] += int'($signed(bus.columnSpeeds_i[c]));
        if ((acc_m[c] >>> SF) >= SCREEN_W)  acc_m[c] -= (SCREEN_W + NUM_W) * 16;
        else if ((acc_m[c] >>> SF) < -NUM_W) acc_m[c] += (SCREEN_W + NUM_W) * 16;
      end
    end
    @(posedge clk);
    #1;
    bus.startOfFrame_i = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y);
    bus.pixelX_i = 11'(x);
    bus.pixelY_i = 11'(y);
  endtask

  task automatic do_reset();
    bus.singleHit_i = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #7;
    total++;
    if (dut_pix() !== 22'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", dut_pix(), 22'd0);
    end
    total++;
    if (bus.showNum_o !== {N{1'b1}}) begin
      bad++; $display("FAIL reset_show: got %h want %h", bus.showNum_o, {N{1'b1}});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_pix(0, 0);
    step(1'b0);
    total++;
    if (dut_pix() !== exp_pix()) begin
      bad++; $display("FAIL reset_idle_pix: got %h want %h", dut_pix(), exp_pix());
    end
  endtask

  task automatic test_static();
    logic [3:0] d0, d17;
    for (int i = 0; i < N; i++) bus.numbersToShow_i[i] = 4'($urandom_range(0, 9));
    d0  = bus.numbersToShow_i[0];
    d17 = bus.numbersToShow_i[17];
    set_pix(150, 80); step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL static_corner: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd0, 6'd0});
    end
    set_pix(182, 80); step(1'b0);
    total++;
    if (dut_pix() !== {1'b0, 5'd0, d0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL static_right_edge: got %h want %h", dut_pix(), {1'b0, 5'd0, d0, 6'd0, 6'd0});
    end
    set_pix(181, 111); step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd31, 6'd31}) begin
      bad++; $display("FAIL static_far_corner: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd31, 6'd31});
    end
    set_pix(150, 112); step(1'b0);
    total++;
    if (dut_pix() !== {1'b0, 5'd0, d0, 6'd31, 6'd31}) begin
      bad++; $display("FAIL static_hold: got %h want %h", dut_pix(), {1'b0, 5'd0, d0, 6'd31, 6'd31});
    end
    set_pix(400, 280); step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd17, d17, 6'd0, 6'd0}) begin
      bad++; $display("FAIL static_last: got %h want %h", dut_pix(), {1'b1, 5'd17, d17, 6'd0, 6'd0});
    end
  endtask

  task automatic test_motion_wrap();
    logic [3:0] d0;
    d0 = bus.numbersToShow_i[0];
    bus.columnSpeeds_i[0] = 16'd16;
    set_pix(151, 80); step(1'b1);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd1, 6'd0}) begin
      bad++; $display("FAIL motion_sof_preupdate: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd1, 6'd0});
    end
    step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL motion_one_px: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd0, 6'd0});
    end
    bus.columnSpeeds_i[0] = 16'd1600;
    for (int k = 0; k < 4; k++) step(1'b1);
    bus.columnSpeeds_i[0] = 16'd1408;
    step(1'b1);
    bus.columnSpeeds_i[0] = 16'd0;
    set_pix(639, 80); step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL motion_at_639: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd0, 6'd0});
    end
    bus.columnSpeeds_i[0] = 16'd16;
    set_pix(0, 80); step(1'b1);
    total++;
    if (dut_pix() !== exp_pix()) begin
      bad++; $display("FAIL motion_wrap_sof: got %h want %h", dut_pix(), exp_pix());
    end
    step(1'b0);
    total++;
    if (dut_pix() !== {1'b0, 5'd0, d0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL motion_wrapped_m32: got %h want %h", dut_pix(), {1'b0, 5'd0, d0, 6'd0, 6'd0});
    end
    step(1'b1);
    step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd31, 6'd0}) begin
      bad++; $display("FAIL motion_clip_m31: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd31, 6'd0});
    end
  endtask

  task automatic test_fraction();
    logic [3:0] d0;
    d0 = bus.numbersToShow_i[0];
    bus.columnSpeeds_i[0] = 16'(-8);
    for (int k = 0; k < 3; k++) step(1'b1);
    set_pix(639, 80); step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL frac_wrap_to_639: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd0, 6'd0});
    end
    bus.columnSpeeds_i[0] = 16'd8;
    step(1'b1);
    step(1'b0);
    total++;
    if (dut_pix() !== {1'b0, 5'd0, d0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL frac_kept_on_wrap: got %h want %h", dut_pix(), {1'b0, 5'd0, d0, 6'd0, 6'd0});
    end
    set_pix(0, 80);
    step(1'b1);
    step(1'b0);
    total++;
    if (dut_pix() !== exp_pix() || bus.numDR_o !== 1'b0) begin
      bad++; $display("FAIL frac_half_px: got %h want %h", dut_pix(), exp_pix());
    end
    step(1'b1);
    step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd31, 6'd0}) begin
      bad++; $display("FAIL frac_full_px: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd31, 6'd0});
    end
    bus.columnSpeeds_i[0] = 16'd0;
  endtask

  task automatic test_hit_lifecycle();
    logic [3:0] d4;
    do_reset();
    bus.columnSpeeds_i = '0;
    d4 = bus.numbersToShow_i[4];
    set_pix(210, 190); step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd4, d4, 6'd10, 6'd10}) begin
      bad++; $display("FAIL hit_before: got %h want %h", dut_pix(), {1'b1, 5'd4, d4, 6'd10, 6'd10});
    end
    bus.singleHit_i[4] = 1'b1;
    step(1'b0);
    bus.singleHit_i = '0;
    for (int f = 1; f <= 452; f++) begin
      if (f == 200) bus.singleHit_i[4] = 1'b1;
      step(1'b1);
      bus.singleHit_i = '0;
      total++;
      if (bus.showNum_o !== exp_show()) begin
        bad++; $display("FAIL hit_show f=%0d: got %h want %h", f, bus.showNum_o, exp_show());
      end
      if (lit4(f) >= 0) begin
        total++;
        if (bus.showNum_o[4] !== 1'(lit4(f))) begin
          bad++; $display("FAIL hit_show4 f=%0d: got %b want %0d", f, bus.showNum_o[4], lit4(f));
        end
      end
      step(1'b0);
      total++;
      if (dut_pix() !== exp_pix()) begin
        bad++; $display("FAIL hit_pix f=%0d: got %h want %h", f, dut_pix(), exp_pix());
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] d0, d3;
    do_reset();
    d0 = bus.numbersToShow_i[0];
    d3 = bus.numbersToShow_i[3];
    bus.columnSpeeds_i = '0;
    bus.columnSpeeds_i[1] = 16'(-640);
    set_pix(170, 80); step(1'b1);
    bus.columnSpeeds_i = '0;
    step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd20, 6'd0}) begin
      bad++; $display("FAIL prio_lower_wins: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd20, 6'd0});
    end
    bus.singleHit_i[0] = 1'b1;
    step(1'b0);
    bus.singleHit_i = '0;
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd20, 6'd0}) begin
      bad++; $display("FAIL prio_hit_cycle: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd20, 6'd0});
    end
    step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd3, d3, 6'd10, 6'd0}) begin
      bad++; $display("FAIL prio_higher_after_hide: got %h want %h", dut_pix(), {1'b1, 5'd3, d3, 6'd10, 6'd0});
    end
  endtask

  task automatic test_random();
    int i, x;
    do_reset();
    for (int n = 0; n < 900; n++) begin
      if (n % 50 == 0)
        for (int c = 0; c < COLS; c++) bus.columnSpeeds_i[c] = 16'(int'($urandom_range(0, 128)) - 64);
      if (n % 97 == 0)
        for (int k = 0; k < N; k++) bus.numbersToShow_i[k] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 0) begin
        set_pix($urandom_range(0, 700), $urandom_range(0, 420));
      end else begin
        i = $urandom_range(0, N - 1);
        x = col_pos(i / ROWS) + int'($urandom_range(0, 40)) - 4;
        set_pix(x < 0 ? 0 : x, Y0 + (i % ROWS) * YS + int'($urandom_range(0, 40)) - 4);
      end
      for (int k = 0; k < N; k++) bus.singleHit_i[k] = ($urandom_range(0, 127) == 0);
      step(n % 3 == 0);
      bus.singleHit_i = '0;
      total++;
      if (dut_pix() !== exp_pix()) begin
        bad++; $display("FAIL rand_pix n=%0d: got %h want %h", n, dut_pix(), exp_pix());
      end
      total++;
      if (bus.showNum_o !== exp_show()) begin
        bad++; $display("FAIL rand_show n=%0d: got %h want %h", n, bus.showNum_o, exp_show());
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] d0, d8;
    do_reset();
    for (int c = 0; c < COLS; c++) bus.columnSpeeds_i[c] = 16'(int'($urandom_range(1, 40)));
    bus.singleHit_i[7] = 1'b1;
    step(1'b0);
    bus.singleHit_i = '0;
    for (int k = 0; k < 392; k++) begin
      step(1'b1);
      step(1'b0);
    end
    total++;
    if (bus.showNum_o !== exp_show() || bus.showNum_o[7] !== 1'b0) begin
      bad++; $display("FAIL areset_preblink: got %h want %h", bus.showNum_o, exp_show());
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (dut_pix() !== 22'd0) begin
      bad++; $display("FAIL areset_outputs: got %h want %h", dut_pix(), 22'd0);
    end
    total++;
    if (bus.showNum_o !== {N{1'b1}}) begin
      bad++; $display("FAIL areset_show: got %h want %h", bus.showNum_o, {N{1'b1}});
    end
    #2;
    rst = 1'b0;
    model_reset();
    bus.columnSpeeds_i = '0;
    d0 = bus.numbersToShow_i[0];
    d8 = bus.numbersToShow_i[8];
    set_pix(150, 80); step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd0, d0, 6'd0, 6'd0}) begin
      bad++; $display("FAIL areset_pos0: got %h want %h", dut_pix(), {1'b1, 5'd0, d0, 6'd0, 6'd0});
    end
    set_pix(250, 280); step(1'b0);
    total++;
    if (dut_pix() !== {1'b1, 5'd8, d8, 6'd0, 6'd0}) begin
      bad++; $display("FAIL areset_pos8: got %h want %h", dut_pix(), {1'b1, 5'd8, d8, 6'd0, 6'd0});
    end
  endtask

  initial begin
    bus.startOfFrame_i  = 1'b0;
    bus.pixelX_i        = '0;
    bus.pixelY_i        = '0;
    bus.numbersToShow_i = '0;
    bus.columnSpeeds_i  = '0;
    bus.singleHit_i     = '0;
    test_reset();
    test_static();
    test_motion_wrap();
    test_fraction();
    test_hit_lifecycle();
    test_priority();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
